// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between I-cache refills
// and D-cache refills/writebacks; one line-sized burst per grant.
module mem_arbiter #(
  parameter  int LINE_WORDS = 8,
  parameter  int ADDR_W     = 32,
  localparam int DATA_W     = 32,
  localparam int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_gnt,
  output logic              d_gnt,
  output logic              i_beat,
  output logic              d_beat,
  output logic              i_done,
  output logic              d_done,
  output logic [IDX_W-1:0]  beat_idx,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_beat,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int                OFF   = $clog2(LINE_WORDS * 4);
  localparam logic [ADDR_W-1:0] ALIGN = {ADDR_W{1'b1}} << OFF;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST, DONE} state_t;

  state_t              r_state;
  logic                r_own_d, r_last_d, r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [IDX_W-1:0]    r_idx;
  logic                r_busy, r_gnt_i, r_gnt_d, r_mem_req, r_done_i, r_done_d;
  logic                w_pick_d, w_burst;

  // D wins when alone, or on a tie when I was granted last.
  assign w_pick_d = d_req & (~i_req | ~r_last_d);
  assign w_burst  = (r_state == BURST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_own_d   <= 1'b0;
      r_last_d  <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_gnt_i   <= 1'b0;
      r_gnt_d   <= 1'b0;
      r_mem_req <= 1'b0;
      r_done_i  <= 1'b0;
      r_done_d  <= 1'b0;
    end else begin
      r_done_i <= 1'b0;
      r_done_d <= 1'b0;
      case (r_state)
        IDLE: if (i_req || d_req) begin
          r_state   <= ISSUE;
          r_own_d   <= w_pick_d;
          r_we      <= w_pick_d & d_we;
          r_addr    <= (w_pick_d ? d_addr : i_addr) & ALIGN;
          r_busy    <= 1'b1;
          r_mem_req <= 1'b1;
          r_gnt_d   <= w_pick_d;
          r_gnt_i   <= ~w_pick_d;
        end
        ISSUE: if (mem_ack) begin
          r_state   <= BURST;
          r_mem_req <= 1'b0;
        end
        BURST: if (mem_beat) begin
          // Last beat leaves the index at LAST; DONE clears it, so no wrap.
          if (r_idx == LAST) begin
            r_state  <= DONE;
            r_done_d <= r_own_d;
            r_done_i <= ~r_own_d;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          r_state  <= IDLE;
          r_last_d <= r_own_d;
          r_idx    <= '0;
          r_busy   <= 1'b0;
          r_gnt_i  <= 1'b0;
          r_gnt_d  <= 1'b0;
          r_we     <= 1'b0;
          r_addr   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign i_gnt     = r_gnt_i;
  assign d_gnt     = r_gnt_d;
  assign i_done    = r_done_i;
  assign d_done    = r_done_d;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign beat_idx  = r_idx;
  assign i_beat    = w_burst & mem_beat & ~r_own_d;
  assign d_beat    = w_burst & mem_beat & r_own_d;
  assign mem_wdata = (w_burst & r_own_d & r_we) ? d_wdata : '0;
  assign rdata     = rst ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level round-robin model
// predicts each grant; every beat, strobe, done and reset value is checked.
module tb_mem_arbiter;
  localparam int LW = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [31:0]   d_wdata;
  logic          i_gnt, d_gnt, i_beat, d_beat, i_done, d_done;
  logic [2:0]    beat_idx;
  logic [31:0]   rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack, mem_beat;
  logic [31:0]   mem_rdata;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  bit m_last_d = 1'b0;   // model: side granted last (0 = I)

  mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .i_beat(i_beat), .d_beat(d_beat),
    .i_done(i_done), .d_done(d_done), .beat_idx(beat_idx), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_beat(mem_beat), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wpat(input int k, input logic [31:0] seed);
    return seed ^ (32'h0101_0101 * k) ^ 32'hA500_0000;
  endfunction

  // One full transaction from IDLE back to IDLE; winner predicted by the model.
  task automatic serve_one(input bit rnd, input bit drop, input int ackdly);
    bit          wd, we;
    logic [31:0] a, seed;
    wd   = d_req && (!i_req || !m_last_d);
    a    = wd ? d_addr : i_addr;
    we   = wd && d_we;
    seed = $urandom;
    tick();  // grant edge
    if (drop) begin
      if (wd) d_req = 1'b0; else i_req = 1'b0;
    end
    for (int c = 0; c <= ackdly; c++) begin
      if (c > 0) tick();
      mem_ack   = (c == ackdly);
      mem_beat  = rnd ? 1'($urandom % 2) : 1'b0;
      mem_rdata = $urandom;
      #1;
      chk("iss_dgnt", d_gnt, wd);
      chk("iss_ignt", i_gnt, !wd);
      chk("iss_busy", busy, 1);
      chk("iss_mreq", mem_req, 1);
      chk("iss_addr", mem_addr, a & ~32'(LW * 4 - 1));
      chk("iss_we", mem_we, we);
      chk("iss_strb", {i_beat, d_beat}, 0);
      chk("iss_idx", beat_idx, 0);
    end
    for (int k = 0; k < LW; k++) begin
      int gaps;
      gaps = rnd ? int'($urandom % 3) : 0;
      for (int g = 0; g < gaps; g++) begin
        tick();
        mem_beat = 1'b0;
        mem_ack  = 1'($urandom % 2);
        #1;
        chk("gap_strb", {i_beat, d_beat}, 0);
        chk("gap_idx", beat_idx, k);
        chk("gap_mreq", mem_req, 0);
      end
      tick();
      mem_beat  = 1'b1;
      mem_ack   = rnd ? 1'($urandom % 2) : 1'b0;
      mem_rdata = $urandom;
      d_wdata   = wpat(k, seed);
      #1;
      chk("beat_own", wd ? d_beat : i_beat, 1);
      chk("beat_oth", wd ? i_beat : d_beat, 0);
      chk("beat_idx", beat_idx, k);
      chk("rdata", rdata, mem_rdata);
      chk("wdata", mem_wdata, we ? wpat(k, seed) : 32'h0);
      chk("beat_done", {i_done, d_done}, 0);
    end
    tick();
    mem_beat = rnd ? 1'($urandom % 2) : 1'b0;
    mem_ack  = 1'b0;
    #1;
    chk("done_own", wd ? d_done : i_done, 1);
    chk("done_oth", wd ? i_done : d_done, 0);
    chk("done_strb", {i_beat, d_beat}, 0);
    chk("done_gnt", wd ? d_gnt : i_gnt, 1);
    m_last_d = wd;
    tick();
    mem_beat = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_gnt", {i_gnt, d_gnt}, 0);
    chk("idle_done", {i_done, d_done}, 0);
    chk("idle_mreq", mem_req, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    m_last_d = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_beat = 0; mem_rdata = 32'hDEAD_BEEF;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {i_gnt, d_gnt}, 0);
    chk("rst_mreq", mem_req, 0);
    chk("rst_idx", beat_idx, 0);
    chk("rst_rdata", rdata, 0);
    #10 rst = 1'b1;
    tick();
    #1;
    chk("no_req_busy", busy, 0);

    // single I read, ack one cycle after mem_req
    i_req = 1; i_addr = 32'h104;
    serve_one(0, 0, 1);
    i_req = 0;

    // tie from reset: D, then I, then D
    pulse_reset();
    i_req = 1; i_addr = 32'h440; d_req = 1; d_addr = 32'h880; d_we = 0;
    serve_one(0, 0, 0);
    chk("rr_last1", m_last_d, 1);
    serve_one(0, 0, 0);
    serve_one(0, 0, 0);
    i_req = 0; d_req = 0;

    // D write at 0x2000
    d_req = 1; d_we = 1; d_addr = 32'h2000;
    serve_one(0, 0, 1);
    // stray beats in ISSUE, stray acks in BURST
    d_we = 0; d_addr = 32'h2A7C;
    serve_one(1, 0, 2);

    // reset mid-burst at beat 3 of a D read
    d_addr = 32'h3040;
    tick();
    mem_ack = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_ack = 0; mem_beat = 1; mem_rdata = $urandom;
      #1;
      chk("pre_rst_idx", beat_idx, k);
    end
    rst = 1'b0;
    m_last_d = 1'b0;
    #1;
    chk("mid_rst_out", {i_gnt, d_gnt, i_beat, d_beat, i_done, d_done, busy, mem_req, mem_we}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_data", {mem_wdata, rdata}, 0);
    chk("mid_rst_idx", beat_idx, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("mid_rst_done", {i_done, d_done}, 0);
    end
    rst = 1'b1; mem_beat = 0;
    serve_one(0, 0, 1);
    d_req = 0;

    // I drops req after grant
    i_req = 1; i_addr = 32'h5F0;
    serve_one(0, 1, 1);
    tick();
    chk("drop_idle", {busy, i_gnt, d_gnt}, 0);

    for (int it = 0; it < 25; it++) begin
      i_req  = 1'($urandom % 2);
      d_req  = 1'($urandom % 2);
      if (!i_req && !d_req) i_req = 1;
      i_addr = $urandom; d_addr = $urandom; d_we = 1'($urandom % 2);
      serve_one(1, ($urandom % 4) == 0, int'($urandom % 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
